rx78_keymatrix: RTL and testbench

Consumer end of the `ps2_key` event stream that `hps_io` produces. Decodes each toggle-flagged PS/2 key event into a press/release on an emulated RX-78 keyboard matrix of 9 rows x 8 columns. Exposes the matrix to the Z80 I/O port logic inside `rx78` as a row-select write and a registered column read. Sits between `hps_io` and `rx78`, in the `clk_vid` domain.

---
 rtl/rx78_kb_pkg.sv | 40 ++++
 rtl/rx78_kb_map.sv | 87 ++++++++
 rtl/rx78_keymatrix.sv | 106 ++++++++++
 tb/tb_rx78_keymatrix.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rx78_kb_pkg.sv
// Shared types and key-position constants for the RX-78 keyboard matrix.
package rx78_kb_pkg;

  localparam int ROWS = 9;
  localparam int COLS = 8;

  // Field order matches ps2_key[9:0].
  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } kb_ev_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } kb_pos_t;

  localparam int ROW_A      = 3;
  localparam int COL_A      = 1;
  localparam int ROW_RETURN = 7;
  localparam int COL_RETURN = 0;
  localparam int ROW_CURSOR = 8;
  localparam int COL_SPACE  = 0;
  localparam int COL_RIGHT  = 3;
  localparam int COL_UP     = 4;
  localparam int COL_DOWN   = 5;
  localparam int COL_LEFT   = 6;
  localparam int COL_SHIFT  = 7;

  function automatic kb_pos_t kb_pos(input int r, input int c);
    kb_pos_t p;
    p.hit = 1'b1;
    p.row = r[3:0];
    p.col = c[2:0];
    return p;
  endfunction

endpackage

// File: rtl/rx78_kb_map.sv
// Combinational PS/2 set-2 scan code to RX-78 matrix position lookup.
module rx78_kb_map
  import rx78_kb_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] row,
  output logic [2:0] col
);

  kb_pos_t pos;

  // Index is {ext, code}; anything not listed is a miss and leaves the matrix alone.
  always_comb begin
    pos = '0;
    case ({ext, code})
      9'h045: pos = kb_pos(0, 0);
      9'h016: pos = kb_pos(0, 1);
      9'h01E: pos = kb_pos(0, 2);
      9'h026: pos = kb_pos(0, 3);
      9'h025: pos = kb_pos(0, 4);
      9'h02E: pos = kb_pos(0, 5);
      9'h036: pos = kb_pos(0, 6);
      9'h03D: pos = kb_pos(0, 7);
      9'h03E: pos = kb_pos(1, 0);
      9'h046: pos = kb_pos(1, 1);
      9'h052: pos = kb_pos(1, 2);
      9'h04C: pos = kb_pos(1, 3);
      9'h041: pos = kb_pos(1, 4);
      9'h04E: pos = kb_pos(1, 5);
      9'h049: pos = kb_pos(1, 6);
      9'h04A: pos = kb_pos(1, 7);
      9'h054: pos = kb_pos(2, 0);
      9'h05B: pos = kb_pos(2, 1);
      9'h05D: pos = kb_pos(2, 2);
      9'h055: pos = kb_pos(2, 3);
      9'h00D: pos = kb_pos(2, 4);
      9'h01C: pos = kb_pos(ROW_A, COL_A);
      9'h032: pos = kb_pos(3, 2);
      9'h021: pos = kb_pos(3, 3);
      9'h023: pos = kb_pos(3, 4);
      9'h024: pos = kb_pos(3, 5);
      9'h02B: pos = kb_pos(3, 6);
      9'h034: pos = kb_pos(3, 7);
      9'h033: pos = kb_pos(4, 0);
      9'h043: pos = kb_pos(4, 1);
      9'h03B: pos = kb_pos(4, 2);
      9'h042: pos = kb_pos(4, 3);
      9'h04B: pos = kb_pos(4, 4);
      9'h03A: pos = kb_pos(4, 5);
      9'h031: pos = kb_pos(4, 6);
      9'h044: pos = kb_pos(4, 7);
      9'h04D: pos = kb_pos(5, 0);
      9'h015: pos = kb_pos(5, 1);
      9'h02D: pos = kb_pos(5, 2);
      9'h01B: pos = kb_pos(5, 3);
      9'h02C: pos = kb_pos(5, 4);
      9'h03C: pos = kb_pos(5, 5);
      9'h02A: pos = kb_pos(5, 6);
      9'h01D: pos = kb_pos(5, 7);
      9'h022: pos = kb_pos(6, 0);
      9'h035: pos = kb_pos(6, 1);
      9'h01A: pos = kb_pos(6, 2);
      9'h05A: pos = kb_pos(ROW_RETURN, COL_RETURN);
      9'h066: pos = kb_pos(7, 1);
      9'h076: pos = kb_pos(7, 2);
      9'h16C: pos = kb_pos(7, 3);
      9'h171: pos = kb_pos(7, 4);
      9'h170: pos = kb_pos(7, 5);
      9'h014: pos = kb_pos(7, 6);
      9'h029: pos = kb_pos(ROW_CURSOR, COL_SPACE);
      9'h174: pos = kb_pos(ROW_CURSOR, COL_RIGHT);
      9'h175: pos = kb_pos(ROW_CURSOR, COL_UP);
      9'h172: pos = kb_pos(ROW_CURSOR, COL_DOWN);
      9'h16B: pos = kb_pos(ROW_CURSOR, COL_LEFT);
      9'h012: pos = kb_pos(ROW_CURSOR, COL_SHIFT);
      9'h059: pos = kb_pos(ROW_CURSOR, COL_SHIFT);
      default: pos = '0;
    endcase
  end

  assign hit = pos.hit;
  assign row = pos.row;
  assign col = pos.col;

endmodule

// File: rtl/rx78_keymatrix.sv
// PS/2 event stream to RX-78 9x8 keyboard matrix with CPU row select and registered column read.
// Optional joystick overlay onto row 8 when RX78_JOY_KEYS_EN is defined.
module rx78_keymatrix #(
  parameter int ROWS = rx78_kb_pkg::ROWS,
  parameter int COLS = rx78_kb_pkg::COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        kb_row_wr,
  input  logic [7:0]  kb_row_data,
`ifdef RX78_JOY_KEYS_EN
  input  logic [31:0] joy1,
`endif
  output logic [7:0]  kb_col
);
  import rx78_kb_pkg::*;

  logic            tog_q;
  logic            s1_valid_reg;
  kb_ev_t          s1_ev_reg;
  logic            map_hit;
  logic [3:0]      map_row;
  logic [2:0]      map_col;
  logic [3:0]      sel_reg;
  logic [COLS-1:0] matrix_reg [ROWS];
  logic [7:0]      joy_overlay;
  logic            unused_data;

  assign unused_data = ^kb_row_data[7:4];

  // Loading tog_q from the live input during reset hides whatever toggle state hps_io left behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q        <= ps2_key[10];
      s1_valid_reg <= 1'b0;
      s1_ev_reg    <= '0;
    end else begin
      tog_q        <= ps2_key[10];
      s1_valid_reg <= (ps2_key[10] != tog_q);
      if (ps2_key[10] != tog_q)
        s1_ev_reg <= kb_ev_t'(ps2_key[9:0]);
    end
  end

  rx78_kb_map u_map (
    .ext  (s1_ev_reg.ext),
    .code (s1_ev_reg.code),
    .hit  (map_hit),
    .row  (map_row),
    .col  (map_col)
  );

  // Lookup result is applied on the same edge it is produced, so press/release lands at N+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        matrix_reg[r] <= '0;
    end else if (s1_valid_reg && map_hit && (int'(map_row) < ROWS)) begin
      matrix_reg[map_row][map_col] <= s1_ev_reg.pressed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      sel_reg <= 4'hF;
    else if (kb_row_wr)
      sel_reg <= kb_row_data[3:0];
  end

`ifdef RX78_JOY_KEYS_EN
  logic [4:0] jk_q;
  logic       unused_joy;

  assign unused_joy = ^joy1[31:5];

  always_ff @(posedge clk) begin
    if (reset)
      jk_q <= '0;
    else
      jk_q <= joy1[4:0];
  end

  // Joystick bits mirror the cursor keys and space; they never touch matrix state.
  always_comb begin
    joy_overlay            = 8'h00;
    joy_overlay[COL_RIGHT] = jk_q[0];
    joy_overlay[COL_LEFT]  = jk_q[1];
    joy_overlay[COL_DOWN]  = jk_q[2];
    joy_overlay[COL_UP]    = jk_q[3];
    joy_overlay[COL_SPACE] = jk_q[4];
  end
`else
  assign joy_overlay = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      kb_col <= 8'h00;
    else if (int'(sel_reg) < ROWS)
      kb_col <= matrix_reg[sel_reg] | ((int'(sel_reg) == ROW_CURSOR) ? joy_overlay : 8'h00);
    else
      kb_col <= 8'h00;
  end

endmodule

// File: tb/tb_rx78_keymatrix.sv
// Directed bench for rx78_keymatrix: reset state, latency, mapping, row select, reset flush, joystick overlay.
module tb_rx78_keymatrix;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        kb_row_wr;
  logic [7:0]  kb_row_data;
  logic [7:0]  kb_col;
`ifdef RX78_JOY_KEYS_EN
  logic [31:0] joy1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Cursor/return/shift table: {ext,code}, row, expected column mask.
  logic [8:0] key_code [6] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h05A, 9'h012};
  logic [3:0] key_row  [6] = '{4'd8,   4'd8,   4'd8,   4'd8,   4'd7,   4'd8};
  logic [7:0] key_mask [6] = '{8'h10,  8'h20,  8'h40,  8'h08,  8'h01,  8'h80};

  always #5 clk = ~clk;

  rx78_keymatrix dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .kb_row_wr   (kb_row_wr),
    .kb_row_data (kb_row_data),
`ifdef RX78_JOY_KEYS_EN
    .joy1        (joy1),
`endif
    .kb_col      (kb_col)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s kb_col=%02h ok", tag, got);
    end else begin
      $display("FAIL %s: kb_col=%02h required=%02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [3:0] s);
    kb_row_wr   = 1'b1;
    kb_row_data = {4'hA, s};
    tick(1);
    kb_row_wr   = 1'b0;
    kb_row_data = 8'h00;
    tick(1);
  endtask

  // Drive one event; returns after the edge where kb_col reflects it (N+3).
  task automatic key(input logic pressed, input logic [8:0] ec);
    ps2_key = {~ps2_key[10], pressed, ec};
    tick(3);
  endtask

  initial begin
    reset       = 1'b1;
    ps2_key     = 11'h400;
    kb_row_wr   = 1'b0;
    kb_row_data = 8'h00;
`ifdef RX78_JOY_KEYS_EN
    joy1        = 32'h0;
`endif
    tick(5);
    reset = 1'b0;
    tick(1);
    check("reset_col", kb_col, 8'h00);
    for (int s = 0; s < 9; s++) begin
      set_sel(4'(s));
      check($sformatf("reset_row%0d", s), kb_col, 8'h00);
    end

    // A press with exact latency, then release.
    set_sel(4'd3);
    ps2_key = {~ps2_key[10], 1'b1, 9'h01C};
    tick(2);
    check("a_press_n2", kb_col, 8'h00);
    tick(1);
    check("a_press_n3", kb_col, 8'h02);
    ps2_key = {~ps2_key[10], 1'b0, 9'h01C};
    tick(2);
    check("a_rel_n2", kb_col, 8'h02);
    tick(1);
    check("a_rel_n3", kb_col, 8'h00);

    // Repeated press and stray release are idempotent.
    key(1'b1, 9'h01C);
    key(1'b1, 9'h01C);
    check("a_press_twice", kb_col, 8'h02);
    key(1'b0, 9'h01C);
    check("a_rel_once", kb_col, 8'h00);
    key(1'b0, 9'h01C);
    check("a_rel_again", kb_col, 8'h00);

    // Back-to-back toggles: space then E0 75.
    set_sel(4'd8);
    ps2_key = {~ps2_key[10], 1'b1, 9'h029};
    tick(1);
    ps2_key = {~ps2_key[10], 1'b1, 9'h175};
    tick(2);
    check("b2b_first", kb_col, 8'h01);
    tick(1);
    check("b2b_both", kb_col, 8'h11);

    // Shared shift bit: last event wins.
    key(1'b1, 9'h012);
    check("lshift_dn", kb_col, 8'h91);
    key(1'b0, 9'h059);
    check("rshift_up", kb_col, 8'h11);
    key(1'b0, 9'h029);
    key(1'b0, 9'h175);
    check("row8_clear", kb_col, 8'h00);

    // Non-extended 0x75 must not alias the cursor-up key.
    key(1'b1, 9'h075);
    check("kp8_noext", kb_col, 8'h00);
    key(1'b0, 9'h075);

    for (int k = 0; k < 6; k++) begin
      set_sel(key_row[k]);
      key(1'b1, key_code[k]);
      check($sformatf("key%0d_dn", k), kb_col, key_mask[k]);
      key(1'b0, key_code[k]);
      check($sformatf("key%0d_up", k), kb_col, 8'h00);
    end

    // Unmapped 0x0E leaves every row clear; out-of-range selects read zero.
    key(1'b1, 9'h00E);
    for (int s = 0; s < 9; s++) begin
      set_sel(4'(s));
      check($sformatf("unmap_row%0d", s), kb_col, 8'h00);
    end
    set_sel(4'd12);
    check("sel12", kb_col, 8'h00);
    key(1'b0, 9'h00E);

    // Row-select latency, and high selects hide a pressed key.
    set_sel(4'd8);
    key(1'b1, 9'h01C);
    kb_row_wr   = 1'b1;
    kb_row_data = 8'h03;
    tick(1);
    kb_row_wr   = 1'b0;
    check("sel_w1_old", kb_col, 8'h00);
    tick(1);
    check("sel_w2_new", kb_col, 8'h02);
    set_sel(4'd11);
    check("sel11_a_dn", kb_col, 8'h00);
    set_sel(4'd9);
    check("sel9_a_dn", kb_col, 8'h00);
    set_sel(4'd3);
    check("sel3_a_dn", kb_col, 8'h02);

    // Reset one cycle after a toggle flushes the pipeline and clears the matrix.
    key(1'b0, 9'h01C);
    ps2_key = {~ps2_key[10], 1'b1, 9'h01C};
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);
    check("rst_mid_col", kb_col, 8'h00);
    set_sel(4'd3);
    check("rst_mid_row3", kb_col, 8'h00);
    tick(3);
    check("rst_mid_late", kb_col, 8'h00);

`ifdef RX78_JOY_KEYS_EN
    set_sel(4'd8);
    joy1 = 32'h11;
    tick(1);
    check("joy_n1", kb_col, 8'h00);
    tick(1);
    check("joy_r_fire", kb_col, 8'h09);
    joy1 = 32'h0F;
    tick(2);
    check("joy_dirs", kb_col, 8'h78);
    joy1 = 32'h10;
    tick(2);
    key(1'b1, 9'h029);
    check("joy_fire_sp", kb_col, 8'h01);
    joy1 = 32'h0;
    tick(2);
    check("joy_off_sp", kb_col, 8'h01);
    key(1'b0, 9'h029);
    check("joy_sp_rel", kb_col, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
